// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, reads one instruction byte per
// fetch over a req/ack port, and holds it for the decoder until it is consumed or redirected.
module fetch_unit #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] mem_addr,
    output logic                mem_req,
    input  logic [7:0]          mem_rdata,
    input  logic                mem_ack,
    input  logic                bus_busy,
    output logic [7:0]          instr,
    output logic                instr_valid,
    output logic                fetch_source,
    input  logic                increment_pc,
    input  logic                jump_en,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [PC_WIDTH-1:0] pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          instr_q, instr_d;
    logic                req_w;

    // The request is withdrawn combinationally while a data access owns the port,
    // so an ack seen in that cycle cannot belong to this fetch.
    assign req_w = (state_q == FETCH) && !bus_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (req_w && mem_ack) begin
                    instr_d = mem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // A redirect overrides a simultaneous consume; no +1 is applied.
                if (jump_en) begin
                    pc_d    = jump_target;
                    state_d = FETCH;
                end else if (increment_pc) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req      = req_w;
    assign mem_addr     = pc_q;
    assign pc           = pc_q;
    assign instr        = instr_q;
    assign instr_valid  = (state_q == HOLD);
    assign fetch_source = (state_q == HOLD);

endmodule
